// File: rtl/invader_fleet_ctl_if.sv
// Fleet controller bus: per-frame inputs (frame_tick, start, alive mask)
// from the game logic and the fleet position/status back to it.
//   master : drives frame_tick, start, alive; observes fleet outputs
//   slave  : the fleet controller itself
interface invader_fleet_ctl_if #(
  parameter int NUM_CELLS = 30
);
  logic                  frame_tick;
  logic                  start;
  logic [NUM_CELLS-1:0]  alive;
  logic signed [11:0]    xpos;
  logic [11:0]           ypos;
  logic                  dir_left;
  logic                  step;
  logic                  wave_clear;
  logic                  invaded;
  logic [1:0]            state;

  modport master (
    output frame_tick, start, alive,
    input  xpos, ypos, dir_left, step, wave_clear, invaded, state
  );

  modport slave (
    input  frame_tick, start, alive,
    output xpos, ypos, dir_left, step, wave_clear, invaded, state
  );
endinterface

// File: rtl/invader_fleet_ctl.sv
// Space-invaders fleet march controller.
// Moves the fleet origin sideways one STEP_X per step period, drops it by
// STEP_Y and reverses when the outermost living column would leave the
// screen, and ends the wave when every invader is dead (CLEAR) or the lowest
// living row reaches INVADE_Y (INVADED). The fleet speeds up as it shrinks.
// Ports:
//   clk   : pixel clock
//   rst   : asynchronous active-low reset, released synchronously to clk
//   fleet : invader_fleet_ctl_if.slave (frame_tick/start/alive in,
//           xpos/ypos/dir_left/step/wave_clear/invaded/state out)
module invader_fleet_ctl #(
  parameter int NUM_INVADERS   = 10,
  parameter int NUM_ROWS       = 3,
  parameter int INVADER_WIDTH  = 64,
  parameter int INVADER_HEIGHT = 32,
  parameter int COL_PITCH      = 96,
  parameter int ROW_PITCH      = 100,
  parameter int X_INIT         = 0,
  parameter int Y_INIT         = 100,
  parameter int STEP_X         = 8,
  parameter int STEP_Y         = 16,
  parameter int SCREEN_W       = 1024,
  parameter int INVADE_Y       = 704,
  parameter int MIN_PERIOD     = 1
) (
  input  logic               clk,
  input  logic               rst,
  invader_fleet_ctl_if.slave fleet
);
  localparam int NUM_CELLS = NUM_ROWS * NUM_INVADERS;
  localparam int COL_W     = (NUM_INVADERS > 1) ? $clog2(NUM_INVADERS) : 1;
  localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CNT_W     = ($clog2(NUM_CELLS + 1) > 5) ? $clog2(NUM_CELLS + 1) : 5;
  localparam int PER_W     = 8;

  localparam logic signed [11:0] X_INIT_S   = 12'(X_INIT);
  localparam logic [11:0]        Y_INIT_U   = 12'(Y_INIT);
  localparam logic signed [11:0] STEP_X_12  = 12'(STEP_X);
  localparam logic [11:0]        STEP_Y_12  = 12'(STEP_Y);
  localparam logic signed [12:0] RIGHT_PAD  = 13'(INVADER_WIDTH + STEP_X);
  localparam logic signed [12:0] STEP_X_13  = 13'(STEP_X);
  localparam logic signed [12:0] SCREEN_13  = 13'(SCREEN_W);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MARCH   = 2'd1,
    S_CLEAR   = 2'd2,
    S_INVADED = 2'd3
  } state_e;

  // Reset asserts immediately; release is delayed two clk edges so every
  // flop leaves reset in the same cycle.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 2'b00;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  // ---------------- fleet shape derivations ----------------
  logic [CNT_W-1:0]        alive_count;
  logic [NUM_INVADERS-1:0] col_any;
  logic [NUM_ROWS-1:0]     row_any;
  logic [COL_W-1:0]        lcol, rcol;
  logic [ROW_W-1:0]        brow;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alive_count = '0;
    col_any     = '0;
    row_any     = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_INVADERS; c++) begin
        alive_count = alive_count + CNT_W'(fleet.alive[r*NUM_INVADERS + c]);
        col_any[c]  = col_any[c] | fleet.alive[r*NUM_INVADERS + c];
        row_any[r]  = row_any[r] | fleet.alive[r*NUM_INVADERS + c];
      end
    end
  end

  // Scan directions make the last hit the lowest/highest index.
  always_comb begin
    lcol = '0;
    rcol = '0;
    brow = '0;
    for (int c = NUM_INVADERS - 1; c >= 0; c--) if (col_any[c]) lcol = COL_W'(c);
    for (int c = 0; c < NUM_INVADERS; c++)      if (col_any[c]) rcol = COL_W'(c);
    for (int r = 0; r < NUM_ROWS; r++)          if (row_any[r]) brow = ROW_W'(r);
  end

  // ---------------- registered state ----------------
  state_e                 state_q, state_d;
  logic signed [11:0]     xpos_q, xpos_d;
  logic [11:0]            ypos_q, ypos_d;
  logic                   dir_left_q, dir_left_d;
  logic                   step_q, step_d;
  logic [PER_W-1:0]       cnt_q, cnt_d;

  // ---------------- step timing and edge tests ----------------
  logic [PER_W-1:0]   period;
  logic               step_hit;
  logic signed [12:0] x_ext, right_edge, left_edge;
  logic [12:0]        y_bottom;
  logic               hit_right, hit_left, invade_hit;

  assign period = PER_W'(MIN_PERIOD) + PER_W'(alive_count >> 2);
  // >= rather than == so a period that shrank below the count steps at once.
  assign step_hit = fleet.frame_tick && (cnt_q >= period - PER_W'(1));

  // 13-bit signed so the screen-edge sums can never wrap.
  always_comb begin
    x_ext      = {xpos_q[11], xpos_q};
    right_edge = x_ext + $signed(13'(rcol) * 13'(COL_PITCH)) + RIGHT_PAD;
    left_edge  = x_ext + $signed(13'(lcol) * 13'(COL_PITCH)) - STEP_X_13;
    hit_right  = right_edge > SCREEN_13;
    hit_left   = left_edge[12];
    y_bottom   = 13'(ypos_q) + 13'(brow) * 13'(ROW_PITCH) + 13'(INVADER_HEIGHT);
    invade_hit = y_bottom >= 13'(INVADE_Y);
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= S_IDLE;
      xpos_q     <= X_INIT_S;
      ypos_q     <= Y_INIT_U;
      dir_left_q <= 1'b0;
      step_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      dir_left_q <= dir_left_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    dir_left_d = dir_left_q;
    cnt_d      = cnt_q;
    step_d     = 1'b0;
    case (state_q)
      S_MARCH: begin
        // Wave end outranks any step; CLEAR outranks INVADED.
        if (fleet.alive == '0) begin
          state_d = S_CLEAR;
        end else if (invade_hit) begin
          state_d = S_INVADED;
        end else if (fleet.frame_tick) begin
          if (step_hit) begin
            cnt_d  = '0;
            step_d = 1'b1;
            if (!dir_left_q) begin
              if (hit_right) begin
                ypos_d     = ypos_q + STEP_Y_12;
                dir_left_d = 1'b1;
              end else begin
                xpos_d = xpos_q + STEP_X_12;
              end
            end else begin
              if (hit_left) begin
                ypos_d     = ypos_q + STEP_Y_12;
                dir_left_d = 1'b0;
              end else begin
                xpos_d = xpos_q - STEP_X_12;
              end
            end
          end else begin
            cnt_d = cnt_q + PER_W'(1);
          end
        end
      end
      default: begin
        if (fleet.start) begin
          state_d    = S_MARCH;
          xpos_d     = X_INIT_S;
          ypos_d     = Y_INIT_U;
          dir_left_d = 1'b0;
          cnt_d      = '0;
        end
      end
    endcase
  end

  assign fleet.xpos       = xpos_q;
  assign fleet.ypos       = ypos_q;
  assign fleet.dir_left   = dir_left_q;
  assign fleet.step       = step_q;
  assign fleet.state      = state_q;
  assign fleet.wave_clear = (state_q == S_CLEAR);
  assign fleet.invaded    = (state_q == S_INVADED);
endmodule

// File: tb/tb_invader_fleet_ctl.sv
// Self-checking bench for invader_fleet_ctl: directed scenarios plus a
// randomized run, all compared against a behavioural fleet model.
module tb_invader_fleet_ctl;
  localparam int NI = 10, NR = 3, NC = NI * NR;
  localparam int INV_W = 64, INV_H = 32, COL_P = 96, ROW_P = 100;
  localparam int X0 = 0, Y0 = 100, SX = 8, SY = 16, SCR_W = 1024;
  localparam int INV_Y = 704, MIN_P = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;

  invader_fleet_ctl_if #(.NUM_CELLS(NC)) fleet();
  invader_fleet_ctl dut (.clk(clk), .rst(rst), .fleet(fleet));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // state: 0 idle, 1 marching, 2 cleared, 3 invaded
  int m_state, m_x, m_y, m_ticks;
  bit m_dir, m_step;

  function automatic int lowest_col(logic [NC-1:0] a);
    int res = -1;
    for (int c = 0; c < NI; c++)
      for (int r = 0; r < NR; r++)
        if (res < 0 && a[r*NI + c]) res = c;
    return (res < 0) ? 0 : res;
  endfunction

  function automatic int highest_col(logic [NC-1:0] a);
    int res = 0;
    for (int c = 0; c < NI; c++)
      for (int r = 0; r < NR; r++)
        if (a[r*NI + c]) res = c;
    return res;
  endfunction

  function automatic int bottom_row(logic [NC-1:0] a);
    int res = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NI; c++)
        if (a[r*NI + c]) res = r;
    return res;
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = X0; m_y = Y0; m_dir = 0; m_step = 0; m_ticks = 0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_edge();
    logic [NC-1:0] a;
    int period;
    a = fleet.alive;
    m_step = 0;
    if (m_state == 1) begin
      if (a == '0) m_state = 2;
      else if (m_y + bottom_row(a) * ROW_P + INV_H >= INV_Y) m_state = 3;
      else if (fleet.frame_tick) begin
        period = MIN_P + $countones(a) / 4;
        if (m_ticks + 1 >= period) begin
          m_ticks = 0;
          m_step = 1;
          if (!m_dir) begin
            if (m_x + highest_col(a) * COL_P + INV_W + SX > SCR_W) begin m_y += SY; m_dir = 1; end
            else m_x += SX;
          end else begin
            if (m_x + lowest_col(a) * COL_P - SX < 0) begin m_y += SY; m_dir = 0; end
            else m_x -= SX;
          end
        end else begin
          m_ticks++;
        end
      end
    end else if (fleet.start) begin
      m_state = 1; m_x = X0; m_y = Y0; m_dir = 0; m_ticks = 0;
    end
  endtask

  function automatic logic [29:0] model_vec();
    return {2'(m_state), 12'(m_x), 12'(m_y), m_dir, m_step, m_state == 2, m_state == 3};
  endfunction

  function automatic logic [29:0] dut_vec();
    return {fleet.state, fleet.xpos, fleet.ypos, fleet.dir_left, fleet.step,
            fleet.wave_clear, fleet.invaded};
  endfunction

  // One clock: model and DUT advance together, outputs settle 1 time unit later.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fleet.start = 1'b0;
    fleet.frame_tick = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    fleet.alive = '1;
    fleet.start = 1'b0;
    fleet.frame_tick = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++; $display("FAIL reset_outputs: got %h expected %h", dut_vec(), model_vec());
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fleet.frame_tick = 1'b1;
      cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL reset_release_idle: got %h expected %h", dut_vec(), model_vec());
      end
    end
    fleet.frame_tick = 1'b0;
  endtask

  task automatic test_first_step();
    fleet.alive = '1;
    fleet.start = 1'b1;
    cycle();
    fleet.start = 1'b0;
    checks++;
    if (fleet.state !== 2'd1) begin
      failures++; $display("FAIL start_to_march: state got %0d expected 1", fleet.state);
    end
    for (int k = 1; k <= 8; k++) begin
      fleet.frame_tick = 1'b1;
      cycle();
      fleet.frame_tick = 1'b0;
      checks++;
      if (fleet.step !== (k == 8)) begin
        failures++; $display("FAIL first_step_tick%0d: step got %b expected %b", k, fleet.step, k == 8);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL first_step_model: got %h expected %h", dut_vec(), model_vec());
      end
    end
    checks++;
    if (fleet.xpos !== 12'sd8) begin
      failures++; $display("FAIL first_step_xpos: got %0d expected 8", fleet.xpos);
    end
    cycle();
    checks++;
    if (fleet.step !== 1'b0) begin
      failures++; $display("FAIL step_one_cycle: step got %b expected 0", fleet.step);
    end
  endtask

  task automatic test_right_edge();
    int nsteps = 1;
    int budget = 0;
    fleet.frame_tick = 1'b1;
    while (nsteps < 14 && budget < 500) begin
      cycle();
      budget++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL right_edge_model: got %h expected %h", dut_vec(), model_vec());
      end
      if (fleet.step) begin
        nsteps++;
        if (nsteps == 12) begin
          checks++;
          if (fleet.xpos !== 12'sd96) begin
            failures++; $display("FAIL step12_xpos: got %0d expected 96", fleet.xpos);
          end
        end
        if (nsteps == 13) begin
          checks++;
          if ({fleet.xpos, fleet.ypos, fleet.dir_left} !== {12'd96, 12'd116, 1'b1}) begin
            failures++; $display("FAIL step13_drop: x=%0d y=%0d dir=%b expected x=96 y=116 dir=1",
                                 fleet.xpos, fleet.ypos, fleet.dir_left);
          end
        end
        if (nsteps == 14) begin
          checks++;
          if (fleet.xpos !== 12'sd88) begin
            failures++; $display("FAIL step14_xpos: got %0d expected 88", fleet.xpos);
          end
        end
      end
    end
    fleet.frame_tick = 1'b0;
    checks++;
    if (nsteps != 14) begin
      failures++; $display("FAIL right_edge_timeout: steps got %0d expected 14", nsteps);
    end
  endtask

  task automatic test_left_edge();
    logic [NC-1:0] a;
    bit prev_dir = 1'b0;
    bit dropped = 1'b0;
    int budget = 0;
    do_reset();
    a = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < 4; c++) a[r*NI + c] = 1'b0;
    fleet.alive = a;
    fleet.start = 1'b1;
    cycle();
    fleet.start = 1'b0;
    fleet.frame_tick = 1'b1;
    while (!dropped && budget < 2000) begin
      prev_dir = fleet.dir_left;
      cycle();
      budget++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL left_edge_model: got %h expected %h", dut_vec(), model_vec());
      end
      if (fleet.step && prev_dir && !fleet.dir_left) dropped = 1'b1;
    end
    fleet.frame_tick = 1'b0;
    checks++;
    if (!dropped || {fleet.xpos, fleet.ypos} !== {-12'sd384, 12'd132}) begin
      failures++; $display("FAIL left_edge_drop: dropped=%b x=%0d y=%0d expected x=-384 y=132",
                           dropped, fleet.xpos, fleet.ypos);
    end
  endtask

  task automatic test_clear();
    logic signed [11:0] x_hold;
    logic [11:0] y_hold;
    // Four ticks into a 5-tick period: the next tick would step.
    for (int i = 0; i < 4; i++) begin
      fleet.frame_tick = 1'b1;
      cycle();
    end
    x_hold = fleet.xpos;
    y_hold = fleet.ypos;
    fleet.alive = '0;
    cycle();
    checks++;
    if ({fleet.state, fleet.wave_clear, fleet.step} !== {2'd2, 1'b1, 1'b0}) begin
      failures++; $display("FAIL clear_entry: state=%0d wave_clear=%b step=%b expected 2 1 0",
                           fleet.state, fleet.wave_clear, fleet.step);
    end
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if ({fleet.xpos, fleet.ypos, fleet.step} !== {x_hold, y_hold, 1'b0}) begin
      failures++; $display("FAIL clear_hold: x=%0d y=%0d step=%b expected x=%0d y=%0d step=0",
                           fleet.xpos, fleet.ypos, fleet.step, x_hold, y_hold);
    end
    fleet.frame_tick = 1'b0;
    fleet.alive = '1;
    fleet.start = 1'b1;
    cycle();
    fleet.start = 1'b0;
    checks++;
    if ({fleet.state, fleet.xpos, fleet.ypos, fleet.wave_clear} !== {2'd1, 12'd0, 12'd100, 1'b0}) begin
      failures++; $display("FAIL clear_restart: state=%0d x=%0d y=%0d expected 1 0 100",
                           fleet.state, fleet.xpos, fleet.ypos);
    end
  endtask

  task automatic test_invaded();
    logic signed [11:0] x_hold;
    int budget = 0;
    do_reset();
    fleet.alive = '0;
    fleet.alive[2*NI + 0] = 1'b1;
    fleet.alive[2*NI + 9] = 1'b1;
    fleet.start = 1'b1;
    cycle();
    fleet.start = 1'b0;
    fleet.frame_tick = 1'b1;
    while (fleet.state !== 2'd3 && budget < 2000) begin
      cycle();
      budget++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL invade_model: got %h expected %h", dut_vec(), model_vec());
      end
    end
    checks++;
    if ({fleet.state, fleet.invaded, fleet.wave_clear, fleet.ypos} !== {2'd3, 1'b1, 1'b0, 12'd484}) begin
      failures++; $display("FAIL invaded_entry: state=%0d invaded=%b y=%0d expected 3 1 484",
                           fleet.state, fleet.invaded, fleet.ypos);
    end
    x_hold = fleet.xpos;
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if ({fleet.xpos, fleet.ypos, fleet.step, fleet.invaded} !== {x_hold, 12'd484, 1'b0, 1'b1}) begin
      failures++; $display("FAIL invaded_hold: x=%0d y=%0d step=%b expected x=%0d y=484 step=0",
                           fleet.xpos, fleet.ypos, fleet.step, x_hold);
    end
    fleet.frame_tick = 1'b0;
    fleet.start = 1'b1;
    cycle();
    fleet.start = 1'b0;
    checks++;
    if ({fleet.state, fleet.xpos, fleet.ypos, fleet.dir_left, fleet.invaded} !==
        {2'd1, 12'd0, 12'd100, 1'b0, 1'b0}) begin
      failures++; $display("FAIL invaded_restart: state=%0d x=%0d y=%0d expected 1 0 100",
                           fleet.state, fleet.xpos, fleet.ypos);
    end
  endtask

  task automatic test_reset_mid_march();
    fleet.alive = '1;
    fleet.frame_tick = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== {2'd0, 12'd0, 12'd100, 4'b0000}) begin
      failures++; $display("FAIL async_reset_mid_march: got %h expected %h",
                           dut_vec(), {2'd0, 12'd0, 12'd100, 4'b0000});
    end
    #1 rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (fleet.step !== 1'b0 || fleet.state !== 2'd0) begin
        failures++; $display("FAIL post_reset_no_step: step=%b state=%0d expected 0 0",
                             fleet.step, fleet.state);
      end
    end
    fleet.frame_tick = 1'b0;
  endtask

  task automatic test_random();
    int idx;
    do_reset();
    fleet.alive = '1;
    for (int i = 0; i < 3000; i++) begin
      fleet.frame_tick = ($urandom_range(0, 3) != 0);
      fleet.start = ($urandom_range(0, 63) == 0);
      if (fleet.start)
        fleet.alive = ($urandom_range(0, 3) == 0) ? '1 : (NC'($urandom) | (NC'(1) << $urandom_range(0, NC-1)));
      else if ($urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, NC-1);
        fleet.alive[idx] = 1'b0;
      end
      cycle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    fleet.start = 1'b0;
    fleet.frame_tick = 1'b0;
  endtask

  initial begin
    fleet.start = 1'b0;
    fleet.frame_tick = 1'b0;
    fleet.alive = '1;
    model_reset();
    test_reset();
    test_first_step();
    test_right_edge();
    test_left_edge();
    test_clear();
    test_invaded();
    test_reset_mid_march();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/invader_fleet_ctl.md
INVADER_FLEET_CTL -- requirements
Module: invader_fleet_ctl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_INVADERS, 10, columns per row
- NUM_ROWS, 3, rows
- INVADER_WIDTH, 64, sprite width in px
- INVADER_HEIGHT, 32, sprite height in px
- COL_PITCH, 96, px between column origins
- ROW_PITCH, 100, px between row origins
- X_INIT, 0, fleet x at wave start
- Y_INIT, 100, fleet y at wave start
- STEP_X, 8, px per horizontal step
- STEP_Y, 16, px per drop
- SCREEN_W, 1024, visible width
- INVADE_Y, 704, y line at which the fleet wins
- MIN_PERIOD, 1, minimum frames per step
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, 65 MHz pixel clock
- rst, in, 1, asynchronous, active-low reset
- frame_tick, in, 1, one-cycle pulse per frame
- start, in, 1, one-cycle wave start request
- alive, in, NUM_ROWS*NUM_INVADERS, 1 = invader alive; bit r*NUM_INVADERS+c is row r, column c
- xpos, out, 12, fleet origin x, two's-complement signed
- ypos, out, 12, fleet origin y, unsigned
- dir_left, out, 1, 1 = marching left
- step, out, 1, one-cycle pulse when xpos or ypos changes
- wave_clear, out, 1, level, asserted in CLEAR
- invaded, out, 1, level, asserted in INVADED
- state, out, 2, IDLE=0, MARCH=1, CLEAR=2, INVADED=3

Function
REQ-003 The FSM SHALL have states IDLE, MARCH, CLEAR and INVADED, all registered on clk.
REQ-004 In IDLE, CLEAR and INVADED, start SHALL load xpos=X_INIT, ypos=Y_INIT, dir_left=0 and frame counter=0, and SHALL enter MARCH on the next cycle.
REQ-005 start SHALL be ignored in MARCH.
REQ-006 Combinational derivations SHALL be:
- alive_count = popcount(alive), 5 bits minimum
- lcol/rcol = lowest/highest column index with any alive bit
- brow = highest row index with any alive bit
REQ-007 The step period SHALL be period = MIN_PERIOD + (alive_count >> 2) frames, recomputed every cycle.
REQ-008 In MARCH, each frame_tick SHALL increment the frame counter.
REQ-009 A step event SHALL occur on a frame_tick where counter >= period-1; the counter then clears to 0. The >= compare ensures a shrunken period steps at the next tick.
REQ-010 On a step event with dir_left=0:
- if xpos + rcol*COL_PITCH + INVADER_WIDTH + STEP_X > SCREEN_W, then ypos += STEP_Y, dir_left <= 1, xpos unchanged
- else xpos += STEP_X
REQ-011 On a step event with dir_left=1:
- if xpos + lcol*COL_PITCH - STEP_X < 0 (signed), then ypos += STEP_Y, dir_left <= 0, xpos unchanged
- else xpos -= STEP_X
REQ-012 All edge arithmetic SHALL be 13-bit signed, so that no wrap occurs.
REQ-013 xpos, ypos and dir_left SHALL update on the clk edge following the triggering frame_tick, and step SHALL pulse high in that same cycle (latency 1).
REQ-014 In MARCH, alive==0 SHALL transition to CLEAR on the next cycle with no further steps.
REQ-015 In MARCH, ypos + brow*ROW_PITCH + INVADER_HEIGHT >= INVADE_Y SHALL transition to INVADED; this is evaluated on registered values every cycle.
REQ-016 If REQ-014 and REQ-015 are both true, CLEAR SHALL take priority.
REQ-017 In CLEAR and INVADED, xpos, ypos and dir_left SHALL hold, and step SHALL be 0.
REQ-018 wave_clear SHALL equal (state==CLEAR) and invaded SHALL equal (state==INVADED).
REQ-019 alive changes mid-period SHALL affect only the next step decision, never the current step.

Reset
REQ-020 rst low SHALL immediately force state=IDLE, xpos=X_INIT, ypos=Y_INIT, dir_left=0, step=0, counter=0, wave_clear=0 and invaded=0, regardless of clk.
REQ-021 Reset asserted mid-MARCH SHALL abort the wave, and no step pulse SHALL occur after deassertion until a new start.
REQ-022 Reset deassertion SHALL be synchronised internally to clk.

Verification
REQ-023 Reset, then start with all 30 alive: state=1 next cycle; period=8, so the first step occurs on the 8th frame_tick, giving xpos=8 and one step pulse.
REQ-024 All alive, 12 steps reach xpos=96; the 13th step gives ypos=116, dir_left=1, xpos=96; the 14th step gives xpos=88.
REQ-025 Kill columns 0..3 only (lcol=4), then march left: drop occurs when xpos-8+384<0, i.e. xpos reaches -384, then ypos+=16 and dir_left=0.
REQ-026 Clear alive to 0 mid-period: state=2 next cycle, wave_clear=1, no step; then start sets xpos=0, ypos=100, state=1.
REQ-027 Force ypos via drops with brow=2 until ypos+232>=704: state=3 and invaded=1, positions frozen; then start re-inits.
REQ-028 Pulse rst low between clk edges during MARCH: outputs are at reset values before the next edge, state=0, and frame_ticks produce no step.
